// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared constants for the RV32 pipeline hazard controller:
//                forwarding-select codes, FSM state encodings and the
//                shadow-record width.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

   // EX operand source selects
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   // Flush sequencer states
   localparam logic [0:0] S_RUN   = 1'b0;
   localparam logic [0:0] S_FLUSH = 1'b1;

   // Shadow record for the default register-index width: four flag bits
   // (valid, we, is_load, one spare) plus rd, rs1 and rs2.
   localparam int REG_ADDR_W_DEF = 5;
   localparam int SHADOW_W       = 4 + 3 * REG_ADDR_W_DEF;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fwd_unit
//  Description : Combinational operand-forwarding select for one EX source
//                register. The younger MEM-stage producer beats the WB-stage
//                producer; x0 never forwards.
//  Ports       : rs                        source index of the EX instruction
//                mem_valid/mem_we/mem_rd   MEM-stage shadow record
//                wb_valid/wb_we/wb_rd      WB-stage shadow record
//                fwd_sel                   FWD_RF / FWD_MEM / FWD_WB
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_fwd_unit
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic                  mem_valid,
   input  logic                  mem_we,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  wb_valid,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   output logic [1:0]            fwd_sel
);

   logic w_mem_hit;
   logic w_wb_hit;

   assign w_mem_hit = mem_valid & mem_we & (mem_rd != '0) & (mem_rd == rs);
   assign w_wb_hit  = wb_valid  & wb_we  & (wb_rd  != '0) & (wb_rd  == rs);

   always_comb begin
      fwd_sel = FWD_RF;
      if (w_mem_hit) begin
         fwd_sel = FWD_MEM;
      end else if (w_wb_hit) begin
         fwd_sel = FWD_WB;
      end
   end

endmodule : hazard_fwd_unit
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline control for the 5-stage RV32 core. Produces PC /
//                IF-DEC / DEC-EX stall and flush controls plus EX operand
//                forwarding selects, from a private shadow of the EX, MEM and
//                WB stage contents. Sequences EX redirects, load-use hazards
//                and data-memory wait states (freeze).
//  Ports       : clk, rst (async, active high)
//                dec_*            decoded fields of the instruction in DEC
//                redirect_ex      branch taken / jump resolved in EX
//                mem_busy         data memory wait state, freezes everything
//                stall_if/dec/ex  hold PC, IF/DEC, DEC/EX + EX/MEM
//                flush_dec/ex     insert bubble into IF/DEC, DEC/EX
//                fwd_a/b_sel      EX operand A/B source
//                perf_*_cnt       saturating counters (HAZARD_PERF_CNT_EN)
//  Options     : define HAZARD_PERF_CNT_EN to add the performance counters.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int FLUSH_EXTRA = 0,
   parameter int PERF_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dec_valid,
   input  logic [REG_ADDR_W-1:0] rs1_dec,
   input  logic [REG_ADDR_W-1:0] rs2_dec,
   input  logic                  rs1_used_dec,
   input  logic                  rs2_used_dec,
   input  logic [REG_ADDR_W-1:0] rd_dec,
   input  logic                  rf_we_dec,
   input  logic                  is_load_dec,
   input  logic                  redirect_ex,
   input  logic                  mem_busy,
   output logic                  stall_if,
   output logic                  stall_dec,
   output logic                  stall_ex,
   output logic                  flush_dec,
   output logic                  flush_ex,
   output logic [1:0]            fwd_a_sel,
`ifdef HAZARD_PERF_CNT_EN
   output logic [1:0]            fwd_b_sel,
   output logic [PERF_W-1:0]     perf_stall_cnt,
   output logic [PERF_W-1:0]     perf_flush_cnt
`else
   output logic [1:0]            fwd_b_sel
`endif
);

   // MEM and WB only ever act as forwarding producers, so they keep just the
   // destination fields; EX keeps everything needed for load-use and
   // forwarding lookups.
   typedef struct packed {
      logic                  valid;
      logic                  we;
      logic                  is_load;
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
   } ex_rec_t;

   typedef struct packed {
      logic                  valid;
      logic                  we;
      logic [REG_ADDR_W-1:0] rd;
   } dst_rec_t;

   localparam logic [1:0] c_flush_reload = 2'(FLUSH_EXTRA);
   localparam bit         c_has_extra    = (FLUSH_EXTRA > 0);

   ex_rec_t    ex_q,   ex_d;
   dst_rec_t   mem_q,  mem_d;
   dst_rec_t   wb_q,   wb_d;
   logic [0:0] state_q, state_d;
   logic [1:0] flush_cnt_q, flush_cnt_d;
   logic       run_q;

   logic       w_frz;
   logic       w_redirect;
   logic       w_redir;
   logic       w_lu;
   logic       w_stall_fe;
   logic       w_flush_ex;
   logic [1:0] w_fwd_a;
   logic [1:0] w_fwd_b;

   // run_q is low during reset and for the first cycle after release; every
   // control term is qualified with it so all outputs stay 0 in that window
   // and the shadow simply follows an unstalled pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- hazards
   assign w_frz      = run_q & mem_busy;
   assign w_redirect = run_q & redirect_ex;
   assign w_redir    = w_redirect & ~w_frz;

   assign w_lu = run_q & dec_valid & ex_q.valid & ex_q.is_load & ex_q.we
               & (ex_q.rd != '0)
               & ((rs1_used_dec & (rs1_dec == ex_q.rd))
                | (rs2_used_dec & (rs2_dec == ex_q.rd)));

   // A redirect kills the stalled DEC instruction anyway, so it overrides the
   // load-use stall; a freeze overrides both.
   assign w_stall_fe = w_frz | (w_lu & ~w_redirect);
   assign w_flush_ex = ~w_frz & (w_redirect | w_lu);

   assign stall_ex  = w_frz;
   assign stall_if  = w_stall_fe;
   assign stall_dec = w_stall_fe;
   assign flush_ex  = w_flush_ex;
   assign flush_dec = ~w_frz & (w_redirect | (state_q == S_FLUSH));

   // ---------------------------------------------------------- shadow advance
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!w_frz) begin
         wb_d  = mem_q;
         mem_d = '{valid: ex_q.valid, we: ex_q.we, rd: ex_q.rd};
         if (w_flush_ex || !dec_valid) begin
            ex_d = '0;
         end else begin
            ex_d = '{valid:   1'b1,
                     we:      rf_we_dec,
                     is_load: is_load_dec,
                     rd:      rd_dec,
                     rs1:     rs1_dec,
                     rs2:     rs2_dec};
         end
      end
   end

   // -------------------------------------------------------- flush sequencer
   // flush_cnt counts the extra flush_dec cycles still owed after the
   // redirect cycle itself; leaving S_FLUSH on the last one.
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         S_RUN: begin
            if (w_redir && c_has_extra) begin
               state_d     = S_FLUSH;
               flush_cnt_d = c_flush_reload;
            end
         end
         S_FLUSH: begin
            if (w_redir) begin
               flush_cnt_d = c_flush_reload;
            end else if (!w_frz) begin
               if (flush_cnt_q == 2'd1) begin
                  state_d     = S_RUN;
                  flush_cnt_d = 2'd0;
               end else begin
                  flush_cnt_d = flush_cnt_q - 2'd1;
               end
            end
         end
         default: begin
            state_d     = S_RUN;
            flush_cnt_d = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         state_q     <= S_RUN;
         flush_cnt_q <= 2'd0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // ------------------------------------------------------------- forwarding
   hazard_fwd_unit #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_fwd_a (
      .rs        (ex_q.rs1),
      .mem_valid (mem_q.valid),
      .mem_we    (mem_q.we),
      .mem_rd    (mem_q.rd),
      .wb_valid  (wb_q.valid),
      .wb_we     (wb_q.we),
      .wb_rd     (wb_q.rd),
      .fwd_sel   (w_fwd_a)
   );

   hazard_fwd_unit #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_fwd_b (
      .rs        (ex_q.rs2),
      .mem_valid (mem_q.valid),
      .mem_we    (mem_q.we),
      .mem_rd    (mem_q.rd),
      .wb_valid  (wb_q.valid),
      .wb_we     (wb_q.we),
      .wb_rd     (wb_q.rd),
      .fwd_sel   (w_fwd_b)
   );

   assign fwd_a_sel = ex_q.valid ? w_fwd_a : FWD_RF;
   assign fwd_b_sel = ex_q.valid ? w_fwd_b : FWD_RF;

`ifdef HAZARD_PERF_CNT_EN
   // --------------------------------------------------- performance counters
   logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
   logic [PERF_W-1:0] perf_flush_q, perf_flush_d;

   always_comb begin
      perf_stall_d = perf_stall_q;
      perf_flush_d = perf_flush_q;
      if (w_stall_fe && (perf_stall_q != '1)) begin
         perf_stall_d = perf_stall_q + 1'b1;
      end
      if (w_redir && (perf_flush_q != '1)) begin
         perf_flush_d = perf_flush_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
`endif

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl (FLUSH_EXTRA = 2).
//                A stage-list model predicts every output each cycle; directed
//                scenarios add literal expectations; a random phase follows.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

   localparam int AW = 5;
   localparam int FX = 2;
   localparam int PW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          dec_valid = 1'b0;
   logic [AW-1:0] rs1_dec = '0, rs2_dec = '0, rd_dec = '0;
   logic          rs1_used_dec = 1'b0, rs2_used_dec = 1'b0;
   logic          rf_we_dec = 1'b0, is_load_dec = 1'b0;
   logic          redirect_ex = 1'b0, mem_busy = 1'b0;
   logic          stall_if, stall_dec, stall_ex, flush_dec, flush_ex;
   logic [1:0]    fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_PERF_CNT_EN
   logic [PW-1:0] perf_stall_cnt, perf_flush_cnt;
`endif

   hazard_ctrl #(.REG_ADDR_W(AW), .FLUSH_EXTRA(FX), .PERF_W(PW)) dut (
      .clk(clk), .rst(rst), .dec_valid(dec_valid),
      .rs1_dec(rs1_dec), .rs2_dec(rs2_dec),
      .rs1_used_dec(rs1_used_dec), .rs2_used_dec(rs2_used_dec),
      .rd_dec(rd_dec), .rf_we_dec(rf_we_dec), .is_load_dec(is_load_dec),
      .redirect_ex(redirect_ex), .mem_busy(mem_busy),
      .stall_if(stall_if), .stall_dec(stall_dec), .stall_ex(stall_ex),
      .flush_dec(flush_dec), .flush_ex(flush_ex),
`ifdef HAZARD_PERF_CNT_EN
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`else
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
`endif
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------ model
   typedef struct {
      bit v; bit we; bit ld;
      int rd; int rs1; int rs2;
   } rec_t;

   rec_t pipe[3];          // 0 = EX, 1 = MEM, 2 = WB
   bit   first_cyc;        // first cycle after reset release
   int   flush_left;       // extra flush_dec cycles still owed
   longint m_stall_cnt, m_flush_cnt;

   bit   m_frz, m_red, m_lu;
   bit   e_stall, e_stall_ex, e_fdec, e_fex;
   int   e_fa, e_fb;

   int checks = 0;
   int errors = 0;

   function automatic void model_reset();
      for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0, 0, 0};
      first_cyc   = 1;
      flush_left  = 0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
   endfunction

   // Nearest older writer of rs wins: MEM (code 1) before WB (code 2).
   function automatic int fwd_of(int rs);
      for (int s = 1; s <= 2; s++)
         if (pipe[s].v && pipe[s].we && pipe[s].rd != 0 && pipe[s].rd == rs)
            return s;
      return 0;
   endfunction

   function automatic void model_eval();
      bit active;
      if (rst) model_reset();
      active = !rst && !first_cyc;
      m_frz  = active && mem_busy;
      m_red  = active && redirect_ex;
      m_lu   = active && dec_valid && pipe[0].v && pipe[0].ld && pipe[0].we &&
               pipe[0].rd != 0 &&
               ((rs1_used_dec && int'(rs1_dec) == pipe[0].rd) ||
                (rs2_used_dec && int'(rs2_dec) == pipe[0].rd));
      e_stall_ex = m_frz;
      e_stall    = m_frz || (m_lu && !m_red);
      e_fex      = !m_frz && (m_red || m_lu);
      e_fdec     = !m_frz && (m_red || flush_left > 0);
      e_fa       = pipe[0].v ? fwd_of(pipe[0].rs1) : 0;
      e_fb       = pipe[0].v ? fwd_of(pipe[0].rs2) : 0;
   endfunction

   function automatic void model_clock();
      model_eval();
      if (rst) begin
         model_reset();
         return;
      end
      if (e_stall) m_stall_cnt++;
      if (m_red && !m_frz) m_flush_cnt++;
      if (!m_frz) begin
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         if (e_fex || !dec_valid) pipe[0] = '{0, 0, 0, 0, 0, 0};
         else pipe[0] = '{1, rf_we_dec, is_load_dec, int'(rd_dec),
                          int'(rs1_dec), int'(rs2_dec)};
         if (m_red) flush_left = FX;
         else if (flush_left > 0) flush_left--;
      end
      first_cyc = 0;
   endfunction

   // ---------------------------------------------------------------- checking
   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      model_eval();
      chk("stall_if",  stall_if,  e_stall);
      chk("stall_dec", stall_dec, e_stall);
      chk("stall_ex",  stall_ex,  e_stall_ex);
      chk("flush_dec", flush_dec, e_fdec);
      chk("flush_ex",  flush_ex,  e_fex);
      chk("fwd_a_sel", fwd_a_sel, e_fa);
      chk("fwd_b_sel", fwd_b_sel, e_fb);
`ifdef HAZARD_PERF_CNT_EN
      chk("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
      chk("perf_flush_cnt", perf_flush_cnt, m_flush_cnt);
`endif
   endtask

   task automatic sample();
      @(negedge clk);
      compare_all();
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic cyc();
      sample();
      tick();
   endtask

   task automatic set_nop();
      dec_valid = 0; rd_dec = 0; rf_we_dec = 0; is_load_dec = 0;
      rs1_dec = 0; rs1_used_dec = 0; rs2_dec = 0; rs2_used_dec = 0;
      redirect_ex = 0; mem_busy = 0;
   endtask

   task automatic set_dec(input int rd, input bit we, input bit ld,
                          input int r1, input bit u1, input int r2, input bit u2);
      dec_valid = 1; rd_dec = AW'(rd); rf_we_dec = we; is_load_dec = ld;
      rs1_dec = AW'(r1); rs1_used_dec = u1; rs2_dec = AW'(r2); rs2_used_dec = u2;
   endtask

   task automatic drain();
      set_nop();
      repeat (4) cyc();
   endtask

   // --------------------------------------------------------------- stimulus
   initial begin
      model_reset();
      mem_busy = 1; redirect_ex = 1;
      repeat (2) tick();
      sample();
      chk("rst_stall_ex", stall_ex, 0);
      chk("rst_flush_dec", flush_dec, 0);
      tick();
      rst = 0;
      // First cycle after release: still all zero despite busy/redirect.
      sample();
      chk("first_stall_ex", stall_ex, 0);
      chk("first_flush_ex", flush_ex, 0);
      tick();
      drain();

      // Load-use: lw x5 in EX, add x6,x5,x7 in DEC.
      set_dec(5, 1, 1, 0, 0, 0, 0); cyc();
      set_dec(6, 1, 0, 5, 1, 7, 1);
      sample();
      chk("lu_stall_if", stall_if, 1);
      chk("lu_stall_dec", stall_dec, 1);
      chk("lu_flush_ex", flush_ex, 1);
      chk("lu_flush_dec", flush_dec, 0);
      tick();
      sample();
      chk("lu_once_stall_if", stall_if, 0);
      chk("lu_once_flush_ex", flush_ex, 0);
      tick();
      set_nop();
      sample();
      chk("lu_fwd_a_wb", fwd_a_sel, 2);
      chk("lu_fwd_b_rf", fwd_b_sel, 0);
      tick();
      drain();

      // MEM beats WB on rs2; then the same with rd = x0.
      set_dec(3, 1, 0, 0, 0, 0, 0); cyc();
      set_dec(3, 1, 0, 0, 0, 0, 0); cyc();
      set_dec(9, 1, 0, 1, 1, 3, 1); cyc();
      set_nop();
      sample();
      chk("fwd_b_mem", fwd_b_sel, 1);
      chk("fwd_a_none", fwd_a_sel, 0);
      tick();
      drain();
      set_dec(0, 1, 0, 0, 0, 0, 0); cyc();
      set_dec(0, 1, 0, 0, 0, 0, 0); cyc();
      set_dec(9, 1, 0, 1, 1, 0, 1); cyc();
      set_nop();
      sample();
      chk("fwd_b_x0", fwd_b_sel, 0);
      tick();
      drain();

      // Redirect with FLUSH_EXTRA = 2: flush_dec for 3 cycles.
      redirect_ex = 1;
      sample();
      chk("redir_fdec0", flush_dec, 1);
      chk("redir_fex0", flush_ex, 1);
      chk("redir_stall0", stall_if, 0);
      tick();
      redirect_ex = 0;
      sample(); chk("redir_fdec1", flush_dec, 1); chk("redir_fex1", flush_ex, 0); tick();
      sample(); chk("redir_fdec2", flush_dec, 1); tick();
      sample(); chk("redir_fdec3", flush_dec, 0); tick();
      drain();

      // Second redirect in cycle 2 extends flush_dec to cycle 4.
      redirect_ex = 1; cyc();
      redirect_ex = 0; cyc();
      redirect_ex = 1;
      sample(); chk("redir2_fex2", flush_ex, 1); tick();
      redirect_ex = 0;
      sample(); chk("redir2_fdec3", flush_dec, 1); tick();
      sample(); chk("redir2_fdec4", flush_dec, 1); tick();
      sample(); chk("redir2_fdec5", flush_dec, 0); tick();
      drain();

      // Freeze defers a redirect.
      redirect_ex = 1; mem_busy = 1;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("frz_stall_if", stall_if, 1);
         chk("frz_stall_ex", stall_ex, 1);
         chk("frz_flush_dec", flush_dec, 0);
         chk("frz_flush_ex", flush_ex, 0);
         tick();
      end
      mem_busy = 0;
      sample();
      chk("unfrz_flush_dec", flush_dec, 1);
      chk("unfrz_flush_ex", flush_ex, 1);
      chk("unfrz_stall_ex", stall_ex, 0);
      tick();
      drain();

      // Load-use and redirect together: redirect wins.
      set_dec(5, 1, 1, 0, 0, 0, 0); cyc();
      set_dec(6, 1, 0, 5, 1, 0, 0);
      redirect_ex = 1;
      sample();
      chk("lu_red_fdec", flush_dec, 1);
      chk("lu_red_fex", flush_ex, 1);
      chk("lu_red_stall", stall_if, 0);
      tick();
      drain();

      // Async reset while in the flush sequence.
      redirect_ex = 1; cyc();
      redirect_ex = 0; mem_busy = 1;
      sample();
      chk("pre_rst_stall_ex", stall_ex, 1);
      #2 rst = 1;
      #1;
      compare_all();
      chk("arst_stall_ex", stall_ex, 0);
      chk("arst_stall_if", stall_if, 0);
`ifdef HAZARD_PERF_CNT_EN
      chk("arst_perf_stall", perf_stall_cnt, 0);
      chk("arst_perf_flush", perf_flush_cnt, 0);
`endif
      tick();
      rst = 0; mem_busy = 0;
      sample(); chk("post_rst_fdec0", flush_dec, 0); tick();
      sample(); chk("post_rst_fdec1", flush_dec, 0); tick();

      // Random traffic, small register range to provoke hazards.
      for (int i = 0; i < 3000; i++) begin
         dec_valid    = ($urandom_range(0, 9) < 8);
         rd_dec       = AW'($urandom_range(0, 7));
         rs1_dec      = AW'($urandom_range(0, 7));
         rs2_dec      = AW'($urandom_range(0, 7));
         rs1_used_dec = $urandom_range(0, 1);
         rs2_used_dec = $urandom_range(0, 1);
         rf_we_dec    = ($urandom_range(0, 3) != 0);
         is_load_dec  = ($urandom_range(0, 2) == 0);
         redirect_ex  = ($urandom_range(0, 9) == 0);
         mem_busy     = ($urandom_range(0, 6) == 0);
         if (i == 1500) rst = 1;
         if (i == 1502) rst = 0;
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_hazard_ctrl
`default_nettype wire
